eth_rx_filter: RTL and testbench

Receive-side Ethernet stage directly upstream of udpip_rx. It takes the MAC byte stream, with FCS already stripped and error-flagged, and checks the destination MAC and the IPv4 EtherType. It stores each accepted payload in a single frame buffer. Only payloads of complete, error-free frames are replayed on the udp_rx/valid/first/last byte interface that udpip_rx consumes, so udpip_rx never sees a frame it would have to retract.

---
 rtl/eth_rx_filter.sv | 174 +++++++++++++++++
 tb/tb_eth_rx_filter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_filter.sv
// Ethernet receive filter: checks destination MAC and EtherType, buffers one payload,
// and replays it to udpip_rx only after the frame has completed without error.
module eth_rx_filter #(
   parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
   parameter bit          ACCEPT_BCAST = 1'b1,
   parameter logic [15:0] ETHERTYPE    = 16'h0800,
   parameter int          MAX_PAYLOAD  = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  mac_rx_data,
   input  logic        mac_rx_valid,
   input  logic        mac_rx_last,
   input  logic        mac_rx_error,
   output logic [7:0]  udp_rx,
   output logic        udp_rx_valid,
   output logic        udp_rx_first,
   output logic        udp_rx_last,
   output logic [7:0]  udp_rx_len,
   output logic [15:0] cnt_ok,
   output logic [15:0] cnt_drop_addr,
   output logic [15:0] cnt_drop_type,
   output logic [15:0] cnt_drop_err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_HDR     = 3'd1;
   localparam logic [2:0] S_PAYLOAD = 3'd2;
   localparam logic [2:0] S_DROP    = 3'd3;
   localparam logic [2:0] S_OUT     = 3'd4;

   localparam int         AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

   logic [2:0]  state, state_nx;
   logic        in_frame, in_frame_nx;
   logic        frame_start;
   logic [3:0]  hdr_idx;
   logic [47:0] dst;
   logic [7:0]  type_hi;
   logic [7:0]  len;
   logic [7:0]  rd_idx;
   logic [7:0]  out_len;
   logic        dst_ok, type_ok;
   logic        inc_ok, inc_addr, inc_type, inc_err;
   logic        wr_en;
   logic [7:0]  buffer [0:MAX_PAYLOAD-1];

   // Frame boundaries are tracked regardless of FSM state so a busy frame's tail is recognised.
   assign in_frame_nx = mac_rx_valid ? !mac_rx_last : in_frame;
   assign frame_start = mac_rx_valid && !in_frame;

   assign dst_ok  = (dst == LOCAL_MAC) || (ACCEPT_BCAST && (&dst));
   assign type_ok = ({type_hi, mac_rx_data} == ETHERTYPE);

   always_comb begin
      state_nx = state;
      inc_ok   = 1'b0;
      inc_addr = 1'b0;
      inc_type = 1'b0;
      inc_err  = 1'b0;
      wr_en    = 1'b0;
      case (state)
         S_IDLE: begin
            if (frame_start) begin
               if (mac_rx_last) inc_err  = 1'b1;
               else             state_nx = S_HDR;
            end
         end
         S_HDR: begin
            if (mac_rx_valid) begin
               if (mac_rx_last) begin
                  inc_err  = 1'b1;
                  state_nx = S_IDLE;
               end else if (hdr_idx == 4'd13) begin
                  if (!dst_ok) begin
                     inc_addr = 1'b1;
                     state_nx = S_DROP;
                  end else if (!type_ok) begin
                     inc_type = 1'b1;
                     state_nx = S_DROP;
                  end else begin
                     state_nx = S_PAYLOAD;
                  end
               end
            end
         end
         S_PAYLOAD: begin
            if (mac_rx_valid) begin
               if (len == MAX_LEN) begin
                  inc_err  = 1'b1;
                  state_nx = mac_rx_last ? S_IDLE : S_DROP;
               end else begin
                  wr_en = 1'b1;
                  if (mac_rx_last) begin
                     if (mac_rx_error) begin
                        inc_err  = 1'b1;
                        state_nx = S_IDLE;
                     end else begin
                        inc_ok   = 1'b1;
                        state_nx = S_OUT;
                     end
                  end
               end
            end
         end
         S_DROP: begin
            if (mac_rx_valid && mac_rx_last) state_nx = S_IDLE;
         end
         S_OUT: begin
            if (frame_start) inc_err = 1'b1;
            if (rd_idx == out_len - 8'd1) state_nx = in_frame_nx ? S_DROP : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         in_frame      <= 1'b0;
         hdr_idx       <= 4'd0;
         dst           <= 48'd0;
         type_hi       <= 8'd0;
         len           <= 8'd0;
         rd_idx        <= 8'd0;
         out_len       <= 8'd0;
         cnt_ok        <= 16'd0;
         cnt_drop_addr <= 16'd0;
         cnt_drop_type <= 16'd0;
         cnt_drop_err  <= 16'd0;
      end else begin
         state    <= state_nx;
         in_frame <= in_frame_nx;

         if (state == S_IDLE && frame_start) begin
            hdr_idx <= 4'd1;
            dst     <= {dst[39:0], mac_rx_data};
         end else if (state == S_HDR && mac_rx_valid) begin
            hdr_idx <= hdr_idx + 4'd1;
            if (hdr_idx < 4'd6)   dst     <= {dst[39:0], mac_rx_data};
            if (hdr_idx == 4'd12) type_hi <= mac_rx_data;
         end

         if (state == S_HDR && state_nx == S_PAYLOAD) len <= 8'd0;
         else if (wr_en)                              len <= len + 8'd1;

         if (wr_en && mac_rx_last && !mac_rx_error) begin
            out_len <= len + 8'd1;
            rd_idx  <= 8'd0;
         end else if (state == S_OUT) begin
            rd_idx <= rd_idx + 8'd1;
         end

         // Counters stick at all-ones rather than wrapping.
         if (inc_ok   && cnt_ok        != 16'hFFFF) cnt_ok        <= cnt_ok + 16'd1;
         if (inc_addr && cnt_drop_addr != 16'hFFFF) cnt_drop_addr <= cnt_drop_addr + 16'd1;
         if (inc_type && cnt_drop_type != 16'hFFFF) cnt_drop_type <= cnt_drop_type + 16'd1;
         if (inc_err  && cnt_drop_err  != 16'hFFFF) cnt_drop_err  <= cnt_drop_err + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) buffer[len[AW-1:0]] <= mac_rx_data;
   end

   // Outputs decode straight from state so an asynchronous reset silences them at once.
   assign udp_rx_valid = (state == S_OUT);
   assign udp_rx       = udp_rx_valid ? buffer[rd_idx[AW-1:0]] : 8'h00;
   assign udp_rx_first = udp_rx_valid && (rd_idx == 8'd0);
   assign udp_rx_last  = udp_rx_valid && (rd_idx == out_len - 8'd1);
   assign udp_rx_len   = out_len;

endmodule

// File: tb/tb_eth_rx_filter.sv
// Bench for eth_rx_filter: table of frames with expected outcome, scoreboard on the
// payload replay, plus hand-written busy-frame and reset-during-output sequences.
module tb_eth_rx_filter;

   localparam logic [47:0] MAC_LOCAL = 48'h02_00_00_00_00_01;
   localparam logic [47:0] MAC_BCAST = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [47:0] MAC_OTHER = 48'h02_00_00_00_00_02;
   localparam logic [47:0] MAC_HIBIT = 48'h82_00_00_00_00_01;
   localparam logic [1:0]  O_FWD = 2'd0, O_ADDR = 2'd1, O_TYPE = 2'd2, O_ERR = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  mac_rx_data = 8'h00;
   logic        mac_rx_valid = 1'b0, mac_rx_last = 1'b0, mac_rx_error = 1'b0;
   logic [7:0]  udp_rx, udp_rx_len;
   logic        udp_rx_valid, udp_rx_first, udp_rx_last;
   logic [15:0] cnt_ok, cnt_drop_addr, cnt_drop_type, cnt_drop_err;
   logic [7:0]  b_udp_rx, b_udp_rx_len;
   logic        b_udp_rx_valid, b_udp_rx_first, b_udp_rx_last;
   logic [15:0] b_cnt_ok, b_cnt_drop_addr, b_cnt_drop_type, b_cnt_drop_err;

   eth_rx_filter dut (
      .clk(clk), .rst_n(rst_n),
      .mac_rx_data(mac_rx_data), .mac_rx_valid(mac_rx_valid),
      .mac_rx_last(mac_rx_last), .mac_rx_error(mac_rx_error),
      .udp_rx(udp_rx), .udp_rx_valid(udp_rx_valid), .udp_rx_first(udp_rx_first),
      .udp_rx_last(udp_rx_last), .udp_rx_len(udp_rx_len),
      .cnt_ok(cnt_ok), .cnt_drop_addr(cnt_drop_addr),
      .cnt_drop_type(cnt_drop_type), .cnt_drop_err(cnt_drop_err)
   );

   eth_rx_filter #(.ACCEPT_BCAST(1'b0)) dut_nobc (
      .clk(clk), .rst_n(rst_n),
      .mac_rx_data(mac_rx_data), .mac_rx_valid(mac_rx_valid),
      .mac_rx_last(mac_rx_last), .mac_rx_error(mac_rx_error),
      .udp_rx(b_udp_rx), .udp_rx_valid(b_udp_rx_valid), .udp_rx_first(b_udp_rx_first),
      .udp_rx_last(b_udp_rx_last), .udp_rx_len(b_udp_rx_len),
      .cnt_ok(b_cnt_ok), .cnt_drop_addr(b_cnt_drop_addr),
      .cnt_drop_type(b_cnt_drop_type), .cnt_drop_err(b_cnt_drop_err)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [17:0] exp_q[$];      // {len, first, last, data}
   bit          nobc_seen = 1'b0;

   always @(negedge clk) begin
      if (udp_rx_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", {14'd0, udp_rx_len, udp_rx_first, udp_rx_last, udp_rx}, 32'hFFFF_FFFF);
         end else begin
            check("out_byte", {14'd0, udp_rx_len, udp_rx_first, udp_rx_last, udp_rx},
                  {14'd0, exp_q.pop_front()});
         end
      end else begin
         check("idle_zero", {22'd0, udp_rx_first, udp_rx_last, udp_rx}, 32'd0);
      end
      if (b_udp_rx_valid) nobc_seen = 1'b1;
   end

   // ---------------- model counters ----------------
   int m_ok = 0, m_addr = 0, m_type = 0, m_err = 0;

   task automatic check_counters(input string tag);
      check({tag, "_cnt_ok"},   {16'd0, cnt_ok},        m_ok);
      check({tag, "_cnt_addr"}, {16'd0, cnt_drop_addr}, m_addr);
      check({tag, "_cnt_type"}, {16'd0, cnt_drop_type}, m_type);
      check({tag, "_cnt_err"},  {16'd0, cnt_drop_err},  m_err);
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         check({tag, "_drain"}, exp_q.size(), 0);
         exp_q.delete();
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- driver ----------------
   task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int plen,
                             input int trunc, input bit err, input logic [7:0] seed,
                             input bit fwd, input bit gaps);
      logic [7:0] fb[$];
      int n;
      for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) fb.push_back(8'hA0 + 8'(i));
      fb.push_back(et[15:8]);
      fb.push_back(et[7:0]);
      for (int i = 0; i < plen; i++) fb.push_back(seed + 8'(i));
      n = (trunc > 0) ? trunc : fb.size();
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
               mac_rx_valid = 1'b0;
               mac_rx_data  = 8'($urandom);
               mac_rx_last  = 1'($urandom_range(0, 1));
               mac_rx_error = 1'($urandom_range(0, 1));
            end
         end
         @(posedge clk); #1;
         mac_rx_valid = 1'b1;
         mac_rx_data  = fb[i];
         mac_rx_last  = (i == n - 1);
         mac_rx_error = (i == n - 1) ? err : 1'($urandom_range(0, 1));
         if (fwd && i == n - 1) begin
            for (int j = 0; j < plen; j++)
               exp_q.push_back({8'(plen), (j == 0), (j == plen - 1), seed + 8'(j)});
         end
      end
      @(posedge clk); #1;
      mac_rx_valid = 1'b0;
      mac_rx_last  = 1'b0;
      mac_rx_error = 1'b0;
      mac_rx_data  = 8'h00;
      if (fwd) begin
         @(negedge clk);
         check("latency_first", {30'd0, udp_rx_valid, udp_rx_first}, 32'd3);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [47:0] dst;
      logic [15:0] et;
      int          plen;
      int          trunc;
      bit          err;
      logic [7:0]  seed;
      logic [1:0]  res;
   } vec_t;

   vec_t vt[15];

   initial begin
      int addr_before;
      vt[0]  = '{MAC_LOCAL, 16'h0800, 26, 0,  1'b0, 8'h00, O_FWD};
      vt[1]  = '{MAC_BCAST, 16'h0800, 12, 0,  1'b0, 8'h40, O_FWD};
      vt[2]  = '{MAC_OTHER, 16'h0800, 10, 0,  1'b0, 8'h10, O_ADDR};
      vt[3]  = '{MAC_OTHER, 16'h0806, 10, 0,  1'b0, 8'h20, O_ADDR};
      vt[4]  = '{MAC_LOCAL, 16'h0806, 16, 0,  1'b0, 8'h30, O_TYPE};
      vt[5]  = '{MAC_LOCAL, 16'h0800, 30, 0,  1'b0, 8'h80, O_FWD};
      vt[6]  = '{MAC_LOCAL, 16'h0800, 20, 0,  1'b1, 8'h50, O_ERR};
      vt[7]  = '{MAC_LOCAL, 16'h0800, 20, 10, 1'b0, 8'h00, O_ERR};
      vt[8]  = '{MAC_LOCAL, 16'h0800, 65, 0,  1'b0, 8'h60, O_ERR};
      vt[9]  = '{MAC_LOCAL, 16'h0800, 64, 0,  1'b0, 8'hC0, O_FWD};
      vt[10] = '{MAC_LOCAL, 16'h0800, 1,  0,  1'b0, 8'h7E, O_FWD};
      vt[11] = '{MAC_LOCAL, 16'h0800, 0,  0,  1'b0, 8'h00, O_ERR};
      vt[12] = '{MAC_LOCAL, 16'h0800, 5,  1,  1'b0, 8'h00, O_ERR};
      vt[13] = '{MAC_HIBIT, 16'h0800, 8,  0,  1'b0, 8'h90, O_ADDR};
      vt[14] = '{MAC_BCAST, 16'h0800, 3,  0,  1'b0, 8'hF0, O_FWD};

      // reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valid", {31'd0, udp_rx_valid}, 32'd0);
      check("reset_len", {24'd0, udp_rx_len}, 32'd0);
      check_counters("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int v = 0; v < 15; v++) begin
         addr_before = b_cnt_drop_addr;
         nobc_seen   = 1'b0;
         send_frame(vt[v].dst, vt[v].et, vt[v].plen, vt[v].trunc, vt[v].err, vt[v].seed,
                    vt[v].res == O_FWD, 1'b1);
         case (vt[v].res)
            O_FWD:   m_ok++;
            O_ADDR:  m_addr++;
            O_TYPE:  m_type++;
            default: m_err++;
         endcase
         drain($sformatf("vec%0d", v));
         check_counters($sformatf("vec%0d", v));
         if (vt[v].dst == MAC_BCAST) begin
            check($sformatf("vec%0d_nobc_valid", v), {31'd0, nobc_seen}, 32'd0);
            check($sformatf("vec%0d_nobc_addr", v), b_cnt_drop_addr, addr_before + 1);
         end
      end

      // busy: second frame begins two cycles into the first frame's replay
      send_frame(MAC_LOCAL, 16'h0800, 26, 0, 1'b0, 8'h00, 1'b1, 1'b0);
      m_ok++;
      @(posedge clk);
      send_frame(MAC_LOCAL, 16'h0800, 26, 0, 1'b0, 8'hA0, 1'b0, 1'b0);
      m_err++;
      drain("busy");
      check_counters("busy");
      send_frame(MAC_LOCAL, 16'h0800, 18, 0, 1'b0, 8'h33, 1'b1, 1'b1);
      m_ok++;
      drain("after_busy");
      check_counters("after_busy");

      // reset while replaying output byte 5
      send_frame(MAC_LOCAL, 16'h0800, 30, 0, 1'b0, 8'h20, 1'b1, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      check("pre_reset_valid", {31'd0, udp_rx_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_valid", {31'd0, udp_rx_valid}, 32'd0);
      exp_q.delete();
      m_ok = 0; m_addr = 0; m_type = 0; m_err = 0;
      check_counters("async_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      send_frame(MAC_LOCAL, 16'h0800, 26, 0, 1'b0, 8'h00, 1'b1, 1'b1);
      m_ok++;
      drain("post_reset");
      check_counters("post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
